// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 game-key decoder: scan codes, key indices,
// frame FSM states and the scan-code to key lookup.
package ps2_pkg;

  localparam int NUM_KEYS = 5;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_CHECK = 1;
  localparam int KEY_RIGHT = 2;
  localparam int KEY_UP    = 3;
  localparam int KEY_DOWN  = 4;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frameState_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } keyHit_t;

  // Arrow keys only exist behind the E0 prefix; space/Enter only without it.
  function automatic keyHit_t keyLookup(input logic [7:0] code, input logic ext);
    keyHit_t r;
    r.hit = 1'b1;
    r.idx = 3'(KEY_LEFT);
    if (ext) begin
      case (code)
        SC_LEFT:  r.idx = 3'(KEY_LEFT);
        SC_RIGHT: r.idx = 3'(KEY_RIGHT);
        SC_UP:    r.idx = 3'(KEY_UP);
        SC_DOWN:  r.idx = 3'(KEY_DOWN);
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_SPACE, SC_ENTER: r.idx = 3'(KEY_CHECK);
        default:            r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_filter.sv
// PS/2 pin conditioning: 2-FF synchronisers on clock and data, a run-length
// glitch filter on the clock, and a one-cycle strobe on each filtered falling edge.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2Clk_i,
  input  logic ps2Data_i,
  output logic dataSync_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clkSync_q, dataSync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
      filt_q     <= 1'b1;
      cnt_q      <= '0;
      fall_q     <= 1'b0;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2Clk_i};
      dataSync_q <= {dataSync_q[0], ps2Data_i};
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      fall_q     <= fall_d;
    end
  end

  // Any sample agreeing with the filtered level restarts the run count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    fall_d = 1'b0;
    if (clkSync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = clkSync_q[1];
        fall_d = filt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign dataSync_o = dataSync_q[1];
  assign fall_o     = fall_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver and five-key game decoder (press pulse + held level).
// Define PS2_AUTOREPEAT_EN to pulse on every make code, including typematic repeats.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [7:0]          scan_code,
  output logic                scan_valid,
  output logic                frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic dataS, fall;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2Clk_i   (ps2_clk),
    .ps2Data_i  (ps2_data),
    .dataSync_o (dataS),
    .fall_o     (fall)
  );

  frameState_e         state_q, state_d;
  logic [2:0]          bitCnt_q, bitCnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                parity_q, parity_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [7:0]          scanCode_q, scanCode_d;
  logic                scanValid_q, scanValid_d;
  logic                frameErr_q, frameErr_d;
  logic                ext_q, ext_d, brk_q, brk_d;
  logic [NUM_KEYS-1:0] held_q, held_d, pulse_q, pulse_d;
  keyHit_t             hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      scanCode_q  <= '0;
      scanValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      held_q      <= '0;
      pulse_q     <= '0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      scanCode_q  <= scanCode_d;
      scanValid_q <= scanValid_d;
      frameErr_q  <= frameErr_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      held_q      <= held_d;
      pulse_q     <= pulse_d;
    end
  end

  // Frame FSM; the watchdog only runs mid-frame and is rearmed by every fall.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tmo_d       = '0;
    scanCode_d  = scanCode_q;
    scanValid_d = 1'b0;
    frameErr_d  = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        if (!dataS) begin
          state_d  = DATA;
          bitCnt_d = '0;
        end else begin
          frameErr_d = 1'b1;
        end
      end
      DATA: if (fall) begin
        shift_d  = {dataS, shift_q[7:1]};
        bitCnt_d = bitCnt_q + 3'd1;
        if (bitCnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        parity_d = dataS;
        state_d  = STOP;
      end
      STOP: if (fall) begin
        state_d = IDLE;
        if (dataS && (^{shift_q, parity_q})) begin
          scanCode_d  = shift_q;
          scanValid_d = 1'b1;
        end else begin
          frameErr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !fall) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 2)) begin
        state_d    = IDLE;
        frameErr_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Prefix tracking and per-key make/break handling on accepted bytes.
  always_comb begin
    hit     = keyLookup(scanCode_q, ext_q);
    ext_d   = ext_q;
    brk_d   = brk_q;
    held_d  = held_q;
    pulse_d = '0;
    if (frameErr_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (scanValid_q) begin
      if (scanCode_q == SC_EXT) begin
        ext_d = 1'b1;
      end else if (scanCode_q == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (hit.hit) begin
          if (brk_q) begin
            held_d[hit.idx] = 1'b0;
          end else begin
            held_d[hit.idx] = 1'b1;
`ifdef PS2_AUTOREPEAT_EN
            pulse_d[hit.idx] = 1'b1;
`else
            pulse_d[hit.idx] = ~held_q[hit.idx];
`endif
          end
        end
      end
    end
  end

  assign key_pulse  = pulse_q;
  assign key_held   = held_q;
  assign scan_code  = scanCode_q;
  assign scan_valid = scanValid_q;
  assign frame_err  = frameErr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed PS/2 frames plus random
// traffic, compared against a scan-code level model of the key decoder.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int FL = 6;
  localparam int TO = 400;
  localparam int H  = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [4:0] key_pulse, key_held;
  logic [7:0] scan_code;
  logic       scan_valid, frame_err;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_pulse  (key_pulse),
    .key_held   (key_held),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Event monitor sampled on the falling clock edge.
  int         scanCnt = 0, errCnt = 0, multiCnt = 0;
  int         errCyc = 0, lastPulseCyc = 0;
  int         pulseCnt [5] = '{default: 0};
  logic [7:0] lastScan = 8'h00;
  logic [4:0] lastPulse = 5'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (scan_valid) begin
        scanCnt++;
        lastScan = scan_code;
      end
      if (frame_err) begin
        errCnt++;
        errCyc = cyc;
      end
      if (key_pulse != 5'b0) begin
        lastPulse = key_pulse;
        lastPulseCyc = cyc;
        if ($countones(key_pulse) > 1) multiCnt++;
      end
      for (int k = 0; k < 5; k++) if (key_pulse[k]) pulseCnt[k]++;
    end
  end

  // Reference model of the decoder, driven by whole bytes.
  int         expPulse [5] = '{default: 0};
  logic [4:0] mHeld = 5'b0;
  bit         mExt = 1'b0, mBrk = 1'b0;
  logic [7:0] mScan = 8'h00;
  bit         autoRep;

  task automatic modelByte(input logic [7:0] b);
    int k;
    if (b == 8'hE0) mExt = 1'b1;
    else if (b == 8'hF0) mBrk = 1'b1;
    else begin
      k = -1;
      if (mExt) begin
        if (b == 8'h6B) k = 0;
        if (b == 8'h74) k = 2;
        if (b == 8'h75) k = 3;
        if (b == 8'h72) k = 4;
      end else if (b == 8'h29 || b == 8'h5A) k = 1;
      if (k >= 0) begin
        if (mBrk) mHeld[k] = 1'b0;
        else begin
          if (!mHeld[k] || autoRep) expPulse[k]++;
          mHeld[k] = 1'b1;
        end
      end
      mExt = 1'b0;
      mBrk = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int stopCyc = 0, lastFallCyc = 0;

  task automatic driveBit(input logic b, input bit glitch, input bit isStop);
    ps2_data = b;
    if (glitch) begin
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (H - 13) @(negedge clk);
    end else repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    lastFallCyc = cyc;
    if (isStop) stopCyc = cyc;
    if (glitch) begin
      repeat (10) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H - 13) @(negedge clk);
    end else repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic sendBits(input logic [7:0] b, input bit badPar, input bit glitch, input int nBits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ badPar, b, 1'b0};
    for (int i = 0; i < nBits; i++) driveBit(fr[i], glitch, i == 10);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit glitch);
    int s0, e0;
    s0 = scanCnt;
    e0 = errCnt;
    sendBits(b, badPar, glitch, 11);
    repeat (H) @(negedge clk);
    if (badPar) begin
      mExt = 1'b0;
      mBrk = 1'b0;
    end else begin
      mScan = b;
      modelByte(b);
    end
    checkOutput($sformatf("scan_strobes_%02h", b), scanCnt - s0, badPar ? 0 : 1);
    checkOutput($sformatf("scan_code_%02h", b), scan_code, mScan);
    checkOutput($sformatf("frame_err_%02h", b), errCnt - e0, badPar ? 1 : 0);
    checkOutput($sformatf("key_held_%02h", b), key_held, mHeld);
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("pulses_key%0d_%02h", k, b), pulseCnt[k], expPulse[k]);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pulse"}, key_pulse, 0);
    checkOutput({tag, "_held"}, key_held, 0);
    checkOutput({tag, "_code"}, scan_code, 0);
    checkOutput({tag, "_valid"}, scan_valid, 0);
    checkOutput({tag, "_err"}, frame_err, 0);
  endtask

  logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h29, 8'h5A, 8'hAA, 8'hFA};

  initial begin
    int e0, s0, r;
    logic [7:0] b;
`ifdef PS2_AUTOREPEAT_EN
    autoRep = 1'b1;
`else
    autoRep = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] extended left make and break");
    applyStimulus(8'hE0, 0, 0);
    applyStimulus(8'h6B, 0, 0);
    checkOutput("left_pulse_bits", lastPulse, 5'b00001);
    checkOutput("left_pulse_latency", lastPulseCyc - stopCyc, FL + 4);
    applyStimulus(8'hE0, 0, 0);
    applyStimulus(8'hF0, 0, 0);
    applyStimulus(8'h6B, 0, 0);

    $display("[TB] space typematic repeat then break");
    repeat (3) applyStimulus(8'h29, 0, 0);
    applyStimulus(8'hF0, 0, 0);
    applyStimulus(8'h29, 0, 0);

    $display("[TB] timeout after four data bits");
    e0 = errCnt;
    s0 = scanCnt;
    sendBits(8'h3C, 0, 0, 5);
    for (int i = 0; i < TO + 100 && errCnt == e0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    mExt = 1'b0;
    mBrk = 1'b0;
    checkOutput("tmo_err_count", errCnt - e0, 1);
    checkOutput("tmo_latency", errCyc - lastFallCyc, FL + 2 + TO);
    checkOutput("tmo_no_scan", scanCnt - s0, 0);
    applyStimulus(8'h29, 0, 0);
    applyStimulus(8'hF0, 0, 0);
    applyStimulus(8'h29, 0, 0);

    $display("[TB] glitched down frame");
    applyStimulus(8'hE0, 0, 0);
    applyStimulus(8'h72, 0, 1);
    applyStimulus(8'hE0, 0, 1);
    applyStimulus(8'hF0, 0, 0);
    applyStimulus(8'h72, 0, 1);

    $display("[TB] parity error then up");
    applyStimulus(8'h5A, 1, 0);
    applyStimulus(8'hE0, 0, 0);
    applyStimulus(8'h75, 0, 0);
    checkOutput("up_pulse_bits", lastPulse, 5'b01000);

    $display("[TB] reset mid-frame");
    checkOutput("held_before_reset", key_held, 5'b01000);
    sendBits(8'h55, 0, 0, 4);
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    checkAllZero("mid_reset");
    reset_n = 1'b1;
    mHeld = 5'b0;
    mExt = 1'b0;
    mBrk = 1'b0;
    mScan = 8'h00;
    repeat (5) @(negedge clk);
    applyStimulus(8'hE0, 0, 0);
    applyStimulus(8'h72, 0, 0);
    checkOutput("down_pulse_bits", lastPulse, 5'b10000);

    $display("[TB] random traffic");
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 10);
      b = (r == 10) ? 8'($urandom) : pool[r];
      applyStimulus(b, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    end

    checkOutput("one_pulse_per_cycle", multiCnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
